// File: rtl/prim_sec_anchor_shadow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prim_sec_anchor_flop / prim_sec_anchor_shadow_ctrl
// Brief    : Two-phase (stage + confirm) write controller for a security
//            anchored configuration register. The committed value is kept
//            next to an inverted shadow copy; any divergence between the two
//            raises a sticky storage error.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Anchor flop: a plain register kept as its own instance so that synthesis
// treats each protected copy as a separate, unmergeable storage element.
// ----------------------------------------------------------------------------
module prim_sec_anchor_flop #(
   parameter int                 Width      = 32,
   parameter logic [Width-1:0]   ResetValue = '0
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [Width-1:0]   d_i,
   output logic [Width-1:0]   q_o
);

   logic [Width-1:0] r_q;

   // Capture the next value every cycle; hold behaviour is built by the caller.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_q <= ResetValue;
      end else begin
         r_q <= d_i;
      end
   end

   assign q_o = r_q;

endmodule

// ----------------------------------------------------------------------------
// Stage / confirm controller with inverted shadow storage.
// ----------------------------------------------------------------------------
module prim_sec_anchor_shadow_ctrl #(
   parameter int                 Width         = 32,
   parameter logic [Width-1:0]   ResetValue    = '0,
   parameter int                 TimeoutCycles = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               wr_en_i,
   input  logic [Width-1:0]   wr_data_i,
   input  logic               rd_en_i,
   output logic [Width-1:0]   q_o,
   output logic               staged_o,
   output logic               commit_o,
   output logic               update_err_o,
   output logic               timeout_o,
   output logic               storage_err_o
);

   // A zero timeout still needs a legal one-bit counter.
   localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam bit c_timeout_en = (TimeoutCycles != 0);
   localparam logic [CntW-1:0] c_cnt_last =
      CntW'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STAGED = 1'b1
   } state_e;

   state_e            r_state;
   logic [CntW-1:0]   r_cnt;
   logic              r_staged_o;
   logic              r_commit_o;
   logic              r_update_err_o;
   logic              r_timeout_o;
   logic              r_storage_err_o;

   logic [Width-1:0]  w_committed_q;
   logic [Width-1:0]  w_shadow_q;
   logic [Width-1:0]  w_staged_q;
   logic [Width-1:0]  w_committed_d;
   logic [Width-1:0]  w_shadow_d;
   logic [Width-1:0]  w_staged_d;
   logic              w_load_stage;
   logic              w_confirm_match;
   logic              w_commit;
   logic              w_storage_mismatch;

   // A write in IDLE opens a stage; a matching write in STAGED commits.
   assign w_load_stage       = (r_state == ST_IDLE) && wr_en_i;
   assign w_confirm_match    = (wr_data_i == w_staged_q);
   assign w_commit           = (r_state == ST_STAGED) && wr_en_i && w_confirm_match;

   // Both protected copies are written in the same cycle so that a legal
   // commit never opens a window where they disagree.
   assign w_committed_d      = w_commit     ? wr_data_i  : w_committed_q;
   assign w_shadow_d         = w_commit     ? ~wr_data_i : w_shadow_q;
   assign w_staged_d         = w_load_stage ? wr_data_i  : w_staged_q;

   assign w_storage_mismatch = (w_committed_q != ~w_shadow_q);

   prim_sec_anchor_flop #(
      .Width      (Width),
      .ResetValue (ResetValue)
   ) u_committed_flop (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (w_committed_d),
      .q_o    (w_committed_q)
   );

   prim_sec_anchor_flop #(
      .Width      (Width),
      .ResetValue (~ResetValue)
   ) u_shadow_flop (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (w_shadow_d),
      .q_o    (w_shadow_q)
   );

   prim_sec_anchor_flop #(
      .Width      (Width),
      .ResetValue ('0)
   ) u_staged_flop (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (w_staged_d),
      .q_o    (w_staged_q)
   );

   // Stage/confirm state machine with registered status and event pulses.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         r_staged_o     <= 1'b0;
         r_commit_o     <= 1'b0;
         r_update_err_o <= 1'b0;
         r_timeout_o    <= 1'b0;
      end else begin
         r_commit_o     <= 1'b0;
         r_update_err_o <= 1'b0;
         r_timeout_o    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (wr_en_i) begin
                  r_state    <= ST_STAGED;
                  r_staged_o <= 1'b1;
                  r_cnt      <= '0;
               end
            end
            ST_STAGED: begin
               if (wr_en_i) begin
                  // Write always wins over a concurrent read or an expiring timer.
                  r_state    <= ST_IDLE;
                  r_staged_o <= 1'b0;
                  if (w_confirm_match) begin
                     r_commit_o <= 1'b1;
                  end else begin
                     r_update_err_o <= 1'b1;
                  end
               end else if (rd_en_i) begin
                  r_state    <= ST_IDLE;
                  r_staged_o <= 1'b0;
               end else if (c_timeout_en && (r_cnt == c_cnt_last)) begin
                  r_state     <= ST_IDLE;
                  r_staged_o  <= 1'b0;
                  r_timeout_o <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CntW'(1);
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_staged_o <= 1'b0;
            end
         endcase
      end
   end

   // Sticky fatal flag: once the two copies disagree it stays set until reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_storage_err_o <= 1'b0;
      end else if (w_storage_mismatch) begin
         r_storage_err_o <= 1'b1;
      end
   end

   assign q_o           = w_committed_q;
   assign staged_o      = r_staged_o;
   assign commit_o      = r_commit_o;
   assign update_err_o  = r_update_err_o;
   assign timeout_o     = r_timeout_o;
   assign storage_err_o = r_storage_err_o;

endmodule
`default_nettype wire

// File: tb/tb_prim_sec_anchor_shadow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prim_sec_anchor_shadow_ctrl
// Brief    : Scoreboard bench for the stage/confirm shadow controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prim_sec_anchor_shadow_ctrl;

   localparam int          W  = 32;
   localparam logic [31:0] RV = 32'h0000_00A5;
   localparam int          TO = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en, rd_en;
   logic [31:0]   wr_data;
   logic [31:0]   q;
   logic          staged, commit, uerr, tmo, serr;

   logic          wr_en2, rd_en2;
   logic [31:0]   wr_data2;
   logic [31:0]   q2;
   logic          staged2, commit2, uerr2, tmo2, serr2;

   logic [31:0]   f_val;

   always #5 clk = ~clk;

   prim_sec_anchor_shadow_ctrl #(.Width(W), .ResetValue(RV), .TimeoutCycles(TO)) dut (
      .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
      .q_o(q), .staged_o(staged), .commit_o(commit), .update_err_o(uerr),
      .timeout_o(tmo), .storage_err_o(serr));

   prim_sec_anchor_shadow_ctrl #(.Width(W), .ResetValue(RV), .TimeoutCycles(0)) dut_nt (
      .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en2), .wr_data_i(wr_data2), .rd_en_i(rd_en2),
      .q_o(q2), .staged_o(staged2), .commit_o(commit2), .update_err_o(uerr2),
      .timeout_o(tmo2), .storage_err_o(serr2));

   typedef struct packed {
      logic [31:0] q;
      logic        staged;
      logic        commit;
      logic        uerr;
      logic        tmo;
      logic        serr;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [31:0] m_q;
   bit          m_stg;
   logic [31:0] m_sv;
   int          m_cnt;
   bit          m_serr;
   bit          m_inject;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic push_exp(input bit c, input bit u, input bit t);
      exp_t e;
      e.q = m_q; e.staged = m_stg; e.commit = c; e.uerr = u; e.tmo = t; e.serr = m_serr;
      sb.push_back(e);
   endtask

   task automatic model_step(input bit wr, input logic [31:0] d, input bit rd);
      bit c, u, t;
      c = 0; u = 0; t = 0;
      if (!m_stg) begin
         if (wr) begin m_stg = 1; m_sv = d; m_cnt = 0; end
      end else if (wr) begin
         m_stg = 0;
         if (d == m_sv) begin m_q = d; c = 1; end
         else u = 1;
      end else if (rd) begin
         m_stg = 0;
      end else if (TO != 0 && m_cnt == TO - 1) begin
         m_stg = 0; t = 1;
      end else begin
         m_cnt++;
      end
      if (m_inject) m_serr = 1;
      m_inject = 0;
      push_exp(c, u, t);
   endtask

   task automatic compare_out();
      exp_t e;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("q_o", q, e.q);
         check("staged_o", {31'd0, staged}, {31'd0, e.staged});
         check("commit_o", {31'd0, commit}, {31'd0, e.commit});
         check("update_err_o", {31'd0, uerr}, {31'd0, e.uerr});
         check("timeout_o", {31'd0, tmo}, {31'd0, e.tmo});
         check("storage_err_o", {31'd0, serr}, {31'd0, e.serr});
      end
   endtask

   task automatic cycle(input bit wr, input logic [31:0] d, input bit rd);
      wr_en = wr; wr_data = d; rd_en = rd;
      model_step(wr, d, rd);
      @(posedge clk); #1;
      compare_out();
      wr_en = 0; rd_en = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 32'h0, 0);
   endtask

   task automatic do_reset();
      rst_n = 0; wr_en = 0; rd_en = 0; wr_data = '0;
      m_q = RV; m_stg = 0; m_sv = '0; m_cnt = 0; m_serr = 0; m_inject = 0;
      push_exp(0, 0, 0);
      @(posedge clk); #1;
      compare_out();
      rst_n = 1;
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 0; wr_en = 0; rd_en = 0; wr_data = '0;
      wr_en2 = 0; rd_en2 = 0; wr_data2 = '0; f_val = '0;
      m_inject = 0;

      // Reset values
      do_reset();
      idle(2);

      // Stage + confirm commit
      cycle(1, 32'hDEAD_BEEF, 0);
      cycle(1, 32'hDEAD_BEEF, 0);
      idle(1);

      // Confirm mismatch, then a single write only stages; abort by read
      cycle(1, 32'h1, 0);
      cycle(1, 32'h2, 0);
      cycle(1, 32'h2, 0);
      idle(1);
      cycle(0, 32'h0, 1);
      idle(1);

      // Read alone in IDLE has no effect
      cycle(0, 32'h0, 1);

      // Timeout after TO idle cycles
      cycle(1, 32'h77, 0);
      idle(6);

      // Confirm arriving in the expiry cycle wins
      cycle(1, 32'h88, 0);
      idle(3);
      cycle(1, 32'h88, 0);
      idle(1);

      // Read abort, then read + confirm in the same cycle
      cycle(1, 32'h5, 0);
      cycle(0, 32'h0, 1);
      cycle(1, 32'h5, 0);
      cycle(1, 32'h5, 1);
      idle(1);

      // Reset in the middle of a stage
      cycle(1, 32'h99, 0);
      do_reset();
      idle(1);

      // Storage fault on the shadow copy
      cycle(1, 32'h1234, 0);
      cycle(1, 32'h1234, 0);
      f_val = ~m_q ^ 32'h0000_0100;
      force dut.w_shadow_q = f_val;
      m_inject = 1;
      cycle(0, 32'h0, 0);
      release dut.w_shadow_q;
      idle(2);
      cycle(1, 32'hCAFE, 0);
      cycle(1, 32'hCAFE, 0);
      idle(2);
      do_reset();
      idle(2);

      // Timeout disabled: stays STAGED for 100 cycles
      wr_en2 = 1; wr_data2 = 32'h42;
      cycle(0, 32'h0, 0);
      wr_en2 = 0;
      check("nt_staged_first", {31'd0, staged2}, 32'd1);
      for (int i = 0; i < 100; i++) begin
         cycle(0, 32'h0, 0);
         check("nt_staged", {31'd0, staged2}, 32'd1);
         check("nt_timeout", {31'd0, tmo2}, 32'd0);
      end
      check("nt_q", q2, RV);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
